// File: rtl/procesador_pkg.sv
// Shared fetch-stage types and defaults.
// Imported by the fetch stage, its IF/ID register and the ROM interface.
package procesador_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HALT
  } fetch_state_t;

  localparam int ADDR_W_DEF = 32;
  localparam int INSTR_W_DEF = 32;
  localparam int IMEM_ADDR_W_DEF = 10;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  function automatic logic misaligned(
    input logic [1:0] lsb
  );
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Synchronous instruction-ROM port between fetch and memory.
// Data answers the enable/address of the previous cycle.
interface instr_fetch_stage_if
  import procesador_pkg::*;
#(
  parameter int IMEM_ADDR_W = IMEM_ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);

  logic                   ImemEn;
  logic [IMEM_ADDR_W-1:0] ImemAddr;
  logic [INSTR_W-1:0]     ImemData;

  modport master (
    output ImemEn,
    output ImemAddr,
    input  ImemData
  );

  modport slave (
    input  ImemEn,
    input  ImemAddr,
    output ImemData
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load enable and sync clear.
// Clear wins over enable and leaves a NOP bubble.
module if_id_reg
  import procesador_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               valid_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;

  // next contents: clear, load or hold
  always_comb begin
    instr_d = instr_q;
    pc_d = pc_q;
    valid_d = valid_q;
    if (clr) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (en) begin
      instr_d = instr_i;
      pc_d = pc_i;
      valid_d = valid_i;
    end
  end

  // register with async active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= NOP_INSTR;
      pc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: issues PCNext to the sync ROM and realigns its
// 1-cycle latency into IF/ID, with stall, flush and run control.
module instr_fetch_stage
  import procesador_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int IMEM_ADDR_W = IMEM_ADDR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                EndFlag,
  input  logic [ADDR_W-1:0]   PCNext,
  input  logic                stall,
  input  logic                flush,
  instr_fetch_stage_if.master imem,
  output logic [INSTR_W-1:0]  InstrD,
  output logic [ADDR_W-1:0]   PCD,
  output logic                ValidD,
  output logic                Halted,
  output logic                AlignErr
);

  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] pcf_q, pcf_d;
  logic vf_q, vf_d;
  logic align_q, align_d;
  logic flush_eff, stall_eff, issue;
  logic ifid_en;
  logic [INSTR_W-1:0] ifid_instr;

  // flush only acts while fetching and overrides stall
  always_comb begin
    flush_eff = flush && (state_q == RUN || state_q == DRAIN);
    stall_eff = stall && !flush_eff;
    issue = (state_q == RUN) && !stall_eff;
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  end

  // next state; a stalled EndFlag waits for release
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: if (EndFlag && !stall_eff) state_d = DRAIN;
      DRAIN: state_d = HALT;
      HALT: if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // ROM port: new issue, or replay in-flight address while stalled
  always_comb begin
    imem.ImemEn = 1'b0;
    imem.ImemAddr = '0;
    Halted = (state_q == HALT);
    unique case (1'b1)
      issue: begin
        imem.ImemEn = 1'b1;
        imem.ImemAddr = PCNext[IMEM_ADDR_W+1:2];
      end
      stall_eff && vf_q: begin
        imem.ImemEn = 1'b1;
        imem.ImemAddr = pcf_q[IMEM_ADDR_W+1:2];
      end
      default: ;
    endcase
  end

  // in-flight tracking and sticky alignment error
  always_comb begin
    pcf_d = issue ? PCNext : pcf_q;
    vf_d = issue ? 1'b1 : (stall_eff ? vf_q : 1'b0);
    align_d = align_q | (issue && misaligned(PCNext[1:0]));
  end

  // in-flight registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcf_q <= '0;
      vf_q <= 1'b0;
      align_q <= 1'b0;
    end else begin
      pcf_q <= pcf_d;
      vf_q <= vf_d;
      align_q <= align_d;
    end
  end

  assign AlignErr = align_q;
  assign ifid_en = !stall_eff;
  assign ifid_instr = vf_q ? imem.ImemData : NOP_INSTR;

  if_id_reg #(
    .ADDR_W(ADDR_W),
    .INSTR_W(INSTR_W),
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk(clk),
    .reset(reset),
    .en(ifid_en),
    .clr(flush_eff),
    .instr_i(ifid_instr),
    .pc_i(pcf_q),
    .valid_i(vf_q),
    .instr_o(InstrD),
    .pc_o(PCD),
    .valid_o(ValidD)
  );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: directed scenarios
// followed by randomized stall/flush/end/start traffic.
module tb_instr_fetch_stage;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int MW = 10;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset, start, EndFlag, stall, flush;
  logic [AW-1:0] PCNext;
  logic [IW-1:0] InstrD;
  logic [AW-1:0] PCD;
  logic ValidD, Halted, AlignErr;

  instr_fetch_stage_if #(.IMEM_ADDR_W(MW), .INSTR_W(IW)) imem ();

  instr_fetch_stage #(
    .ADDR_W(AW),
    .INSTR_W(IW),
    .IMEM_ADDR_W(MW),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .EndFlag(EndFlag),
    .PCNext(PCNext),
    .stall(stall),
    .flush(flush),
    .imem(imem),
    .InstrD(InstrD),
    .PCD(PCD),
    .ValidD(ValidD),
    .Halted(Halted),
    .AlignErr(AlignErr)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [1024];

  always @(posedge clk)
    if (imem.ImemEn) imem.ImemData <= rom[imem.ImemAddr];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_HALT} mode_t;

  fetch_t exp_q[$];
  fetch_t last;
  int errors = 0;
  int checks = 0;
  bit cap_next = 1'b0;
  bit mon_en = 1'b0;
  mode_t mode = M_IDLE;
  bit inflight = 1'b0;
  logic [31:0] inflight_pc = '0;
  logic [31:0] cur_pc = '0;
  bit exp_align = 1'b0;

  function automatic logic [31:0] word_idx(input logic [31:0] pc);
    return (pc / 4) % 1024;
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return rom[word_idx(pc)];
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one cycle: drive at negedge, predict, check ROM port, advance model
  task automatic step(input bit st, input bit fl, input bit ef,
                      input bit sta);
    bit run, fe, se, iss, rep;
    logic [31:0] exp_addr;
    stall = st;
    flush = fl;
    EndFlag = ef;
    start = sta;
    PCNext = cur_pc;
    run = (mode == M_RUN);
    fe = fl && (run || mode == M_DRAIN);
    se = st && !fe;
    iss = run && !se;
    rep = se && inflight;
    if (fe && inflight && exp_q.size() > 0) void'(exp_q.pop_back());
    cap_next = !se;
    #1;
    exp_addr = iss ? word_idx(cur_pc) : (rep ? word_idx(inflight_pc) : 0);
    chk("imem_en", imem.ImemEn, iss || rep);
    chk("imem_addr", imem.ImemAddr, exp_addr);
    chk("halted", Halted, mode == M_HALT);
    chk("align_err", AlignErr, exp_align);
    if (iss) begin
      exp_q.push_back(fetch_t'{cur_pc, rom_word(cur_pc)});
      if (cur_pc[1:0] != 2'b00) exp_align = 1'b1;
      inflight = 1'b1;
      inflight_pc = cur_pc;
    end else if (!se) begin
      inflight = 1'b0;
    end
    case (mode)
      M_IDLE: if (sta) mode = M_RUN;
      M_RUN: if (ef && !se) mode = M_DRAIN;
      M_DRAIN: mode = M_HALT;
      M_HALT: if (sta) mode = M_RUN;
      default: mode = M_IDLE;
    endcase
    if (iss) cur_pc = cur_pc + 4;
    @(negedge clk);
  endtask

  // monitor: compare IF/ID against the scoreboard after each edge
  initial begin : monitor
    bit c;
    fetch_t e;
    forever begin
      @(posedge clk);
      c = cap_next;
      #1;
      if (mon_en && reset) begin
        if (c) begin
          if (ValidD) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_valid: got PCD %h nothing expected",
                       PCD);
            end else begin
              e = exp_q.pop_front();
              last = e;
              chk("pcd", PCD, e.pc);
              chk("instr", InstrD, e.instr);
            end
          end else begin
            chk("bubble_instr", InstrD, NOP);
          end
          chk("backlog", exp_q.size() > 1, 0);
        end else if (ValidD) begin
          chk("stall_pcd", PCD, last.pc);
          chk("stall_instr", InstrD, last.instr);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [31:0] t;
    bit st, fl, ef, sta;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[0] = 32'h6500_0007;
    rom[1] = 32'hC000_0050;
    reset = 1'b0;
    start = 1'b0;
    EndFlag = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    PCNext = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", ValidD, 0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_pcd", PCD, 0);
    chk("rst_imem_en", imem.ImemEn, 0);
    chk("rst_imem_addr", imem.ImemAddr, 0);
    chk("rst_halted", Halted, 0);
    chk("rst_align", AlignErr, 0);
    reset = 1'b1;
    mon_en = 1'b1;

    // start, then 0,4,8
    cur_pc = 32'h0;
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    // hold IF/ID for three cycles, then resume
    repeat (3) step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    // taken branch to 0x50
    cur_pc = 32'h50;
    step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    // branch together with stall
    cur_pc = 32'h80;
    step(1, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    // program end at 0x13C, drain, halt, restart at 0
    cur_pc = 32'h134;
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    cur_pc = 32'h0;
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    // misaligned fetch
    cur_pc = 32'h6;
    step(0, 0, 0, 0);
    cur_pc = 32'h100;
    repeat (3) step(0, 0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      st = ($urandom % 4) == 0;
      fl = (mode == M_RUN) && (($urandom % 10) == 0);
      ef = (mode == M_RUN) && (($urandom % 25) == 0);
      sta = (mode == M_HALT || mode == M_IDLE) && (($urandom % 3) == 0);
      if (fl) begin
        t = $urandom;
        t[1:0] = 2'b00;
        cur_pc = t;
      end
      step(st, fl, ef, sta);
    end

    // async reset in the middle of RUN
    for (int k = 0; k < 4 && mode != M_RUN; k++) step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    chk("pre_reset_valid", ValidD, 1);
    mon_en = 1'b0;
    PCNext = 32'h44;
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", ValidD, 0);
    chk("async_instr", InstrD, NOP);
    chk("async_pcd", PCD, 0);
    chk("async_imem_en", imem.ImemEn, 0);
    chk("async_imem_addr", imem.ImemAddr, 0);
    chk("async_halted", Halted, 0);
    chk("async_align", AlignErr, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    mode = M_IDLE;
    inflight = 1'b0;
    exp_align = 1'b0;
    mon_en = 1'b1;
    cur_pc = 32'h0;
    step(0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
